// File: rtl/mcb_port_emulator.sv
// ---------------------------------------------------------------------------
// mcb_port_emulator
//
// Behavioural stand-in for one Spartan-6 MCB user port. It accepts the
// command / write-data / read-data FIFO handshakes that mcb_instr_ctrl drives
// and services them from an on-chip block-RAM array, so the USB<->memory
// datapath can run without external DDR2.
//
// Ports
//   clk_i, rst_i                 single clock, synchronous active-high reset
//   calib_done                   port ready, CALIB_CYCLES edges after reset
//   cmd_en/instr/bl/byte_addr    command push; cmd_empty/cmd_full status
//   wr_en/mask/data              write-data push; wr_full/empty/count status,
//                                sticky wr_underrun (burst starved) and
//                                wr_error (push while full)
//   rd_en, rd_data               read-data pop, first-word fall-through head;
//                                rd_full/empty/count status, sticky
//                                rd_overflow (word dropped) and rd_error
//                                (pop while empty)
//
// Also contains mcb_emu_fifo, the synchronous FIFO used for all three queues.
// ---------------------------------------------------------------------------

// Synchronous FIFO with registered occupancy. The head word is presented
// combinationally (fall-through) and reads as zero while empty. A push is
// refused while full even when a pop happens on the same edge.
module mcb_emu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o   = (count_q == CW'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign data_o   = empty_o ? '0 : store_q[rd_ptr_q];
    assign count_o  = count_q;

    assign wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    assign count_d  = count_q + CW'(do_push) - CW'(do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage arrays carry no reset; flushing the pointers is enough
    // and keeps the array mappable onto RAM primitives.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            store_q[wr_ptr_q] <= data_i;
        end
    end
endmodule

module mcb_port_emulator #(
    parameter int DATA_PORT_SIZE = 64,
    parameter int MASK_SIZE      = 8,
    parameter int MEM_AW         = 10,
    parameter int CMD_DEPTH      = 4,
    parameter int CALIB_CYCLES   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    output logic                      calib_done,
    input  logic                      cmd_en,
    input  logic [2:0]                cmd_instr,
    input  logic [5:0]                cmd_bl,
    input  logic [29:0]               cmd_byte_addr,
    output logic                      cmd_empty,
    output logic                      cmd_full,
    input  logic                      wr_en,
    input  logic [MASK_SIZE-1:0]      wr_mask,
    input  logic [DATA_PORT_SIZE-1:0] wr_data,
    output logic                      wr_full,
    output logic                      wr_empty,
    output logic [6:0]                wr_count,
    output logic                      wr_underrun,
    output logic                      wr_error,
    input  logic                      rd_en,
    output logic [DATA_PORT_SIZE-1:0] rd_data,
    output logic                      rd_full,
    output logic                      rd_empty,
    output logic [6:0]                rd_count,
    output logic                      rd_overflow,
    output logic                      rd_error
);
    localparam int BPW     = DATA_PORT_SIZE / 8;
    localparam int OFS     = $clog2(BPW);
    localparam int CCW     = $clog2(CALIB_CYCLES + 1);
    localparam int CMD_W   = 3 + 6 + 30;
    localparam int WF_W    = MASK_SIZE + DATA_PORT_SIZE;
    localparam int CMD_CW  = $clog2(CMD_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_NOP
    } state_e;

    // ---------------- calibration ----------------
    logic [CCW-1:0] calib_cnt_q;
    logic           calib_done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            calib_cnt_q  <= '0;
            calib_done_q <= 1'b0;
        end else if (!calib_done_q) begin
            // The edge that sees count CALIB_CYCLES-1 is the CALIB_CYCLES-th
            // edge after reset release.
            if (calib_cnt_q == CCW'(CALIB_CYCLES - 1)) begin
                calib_done_q <= 1'b1;
            end
            calib_cnt_q <= calib_cnt_q + CCW'(1);
        end
    end

    assign calib_done = calib_done_q;

    // ---------------- FIFOs ----------------
    logic [CMD_W-1:0]              cmd_head;
    logic [CMD_CW-1:0]             cmd_count_unused;
    logic [2:0]                    head_instr;
    logic [5:0]                    head_bl;
    logic [29:0]                   head_addr;
    logic                          cmd_pop;

    logic [WF_W-1:0]               wf_head;
    logic [MASK_SIZE-1:0]          wf_mask;
    logic [DATA_PORT_SIZE-1:0]     wf_data;
    logic                          wf_pop;

    logic                          rd_valid_q;
    logic [DATA_PORT_SIZE-1:0]     rd_word_q;

    mcb_emu_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cmd_en && calib_done_q),
        .data_i  ({cmd_instr, cmd_bl, cmd_byte_addr}),
        .pop_i   (cmd_pop),
        .data_o  (cmd_head),
        .full_o  (cmd_full),
        .empty_o (cmd_empty),
        .count_o (cmd_count_unused)
    );

    assign {head_instr, head_bl, head_addr} = cmd_head;

    mcb_emu_fifo #(.WIDTH(WF_W), .DEPTH(64)) u_wr_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (wr_en && calib_done_q),
        .data_i  ({wr_mask, wr_data}),
        .pop_i   (wf_pop),
        .data_o  (wf_head),
        .full_o  (wr_full),
        .empty_o (wr_empty),
        .count_o (wr_count)
    );

    assign {wf_mask, wf_data} = wf_head;

    mcb_emu_fifo #(.WIDTH(DATA_PORT_SIZE), .DEPTH(64)) u_rd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rd_valid_q),
        .data_i  (rd_word_q),
        .pop_i   (rd_en && calib_done_q),
        .data_o  (rd_data),
        .full_o  (rd_full),
        .empty_o (rd_empty),
        .count_o (rd_count)
    );

    // Byte-address offset bits and the auto-precharge bit play no part in
    // the emulation.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{head_addr[29:OFS+MEM_AW], head_addr[OFS-1:0],
                               head_instr[1], cmd_count_unused};

    // ---------------- sequencer ----------------
    state_e              state_q, state_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [6:0]          remain_q, remain_d;
    logic                mem_we;
    logic                issue_rd;
    logic                set_underrun;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remain_d     = remain_q;
        cmd_pop      = 1'b0;
        wf_pop       = 1'b0;
        mem_we       = 1'b0;
        issue_rd     = 1'b0;
        set_underrun = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!cmd_empty) begin
                    cmd_pop  = 1'b1;
                    addr_d   = head_addr[OFS +: MEM_AW];
                    remain_d = 7'(head_bl) + 7'd1;
                    // Bit 1 only selects auto-precharge; bit 2 set means
                    // refresh or an unsupported code.
                    if (head_instr[2]) begin
                        state_d = S_NOP;
                    end else if (head_instr[0]) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // A starved beat still consumes its address slot.
                if (!wr_empty) begin
                    wf_pop = 1'b1;
                    mem_we = 1'b1;
                end else begin
                    set_underrun = 1'b1;
                end
                addr_d   = addr_q + MEM_AW'(1);
                remain_d = remain_q - 7'd1;
                if (remain_q == 7'd1) begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                // One extra cycle after the last issue lets the final word
                // land in the read FIFO before the next command decodes.
                if (remain_q != 7'd0) begin
                    issue_rd = 1'b1;
                    addr_d   = addr_q + MEM_AW'(1);
                    remain_d = remain_q - 7'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_NOP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            rd_valid_q  <= 1'b0;
            wr_underrun <= 1'b0;
            wr_error    <= 1'b0;
            rd_overflow <= 1'b0;
            rd_error    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            rd_valid_q <= issue_rd;
            if (set_underrun) begin
                wr_underrun <= 1'b1;
            end
            if (wr_en && calib_done_q && wr_full) begin
                wr_error <= 1'b1;
            end
            if (rd_valid_q && rd_full) begin
                rd_overflow <= 1'b1;
            end
            if (rd_en && calib_done_q && rd_empty) begin
                rd_error <= 1'b1;
            end
        end
    end

    // ---------------- backing array ----------------
    logic [DATA_PORT_SIZE-1:0] mem_q [2**MEM_AW];

    // Contents survive rst_i; a reset edge landing mid-burst must not commit
    // the beat that was in flight.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            for (int b = 0; b < BPW; b++) begin
                if (!wf_mask[b]) begin
                    mem_q[addr_q][8*b +: 8] <= wf_data[8*b +: 8];
                end
            end
        end
        if (issue_rd) begin
            rd_word_q <= mem_q[addr_q];
        end
    end
endmodule

// File: tb/tb_mcb_port_emulator.sv
// ---------------------------------------------------------------------------
// tb_mcb_port_emulator
//
// Directed self-checking bench for mcb_port_emulator. Inputs change and
// outputs are sampled just after the falling clock edge; every expected
// value is a hand-computed constant.
// ---------------------------------------------------------------------------
module tb_mcb_port_emulator;
    logic        clk_i;
    logic        rst_i;
    logic        calib_done;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_empty, cmd_full;
    logic        wr_en;
    logic [7:0]  wr_mask;
    logic [63:0] wr_data;
    logic        wr_full, wr_empty;
    logic [6:0]  wr_count;
    logic        wr_underrun, wr_error;
    logic        rd_en;
    logic [63:0] rd_data;
    logic        rd_full, rd_empty;
    logic [6:0]  rd_count;
    logic        rd_overflow, rd_error;

    int checks = 0;
    int errors = 0;

    mcb_port_emulator dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .calib_done    (calib_done),
        .cmd_en        (cmd_en),
        .cmd_instr     (cmd_instr),
        .cmd_bl        (cmd_bl),
        .cmd_byte_addr (cmd_byte_addr),
        .cmd_empty     (cmd_empty),
        .cmd_full      (cmd_full),
        .wr_en         (wr_en),
        .wr_mask       (wr_mask),
        .wr_data       (wr_data),
        .wr_full       (wr_full),
        .wr_empty      (wr_empty),
        .wr_count      (wr_count),
        .wr_underrun   (wr_underrun),
        .wr_error      (wr_error),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_full       (rd_full),
        .rd_empty      (rd_empty),
        .rd_count      (rd_count),
        .rd_overflow   (rd_overflow),
        .rd_error      (rd_error)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic push_wr(input logic [63:0] data, input logic [7:0] mask);
        wr_en   = 1'b1;
        wr_data = data;
        wr_mask = mask;
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic send_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
        cmd_en        = 1'b1;
        cmd_instr     = instr;
        cmd_bl        = bl;
        cmd_byte_addr = addr;
        tick(1);
        cmd_en        = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] bl, input logic [29:0] addr);
        send_cmd(3'b000, bl, addr);
        tick(int'(bl) + 5);
    endtask

    task automatic do_read(input logic [5:0] bl, input logic [29:0] addr);
        send_cmd(3'b001, bl, addr);
        tick(int'(bl) + 6);
    endtask

    task automatic pop_check(input string tag, input logic [63:0] exp);
        check(tag, rd_data, exp);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; cmd_en = 1'b0; cmd_instr = '0; cmd_bl = '0; cmd_byte_addr = '0;
        wr_en = 1'b0; wr_mask = '0; wr_data = '0; rd_en = 1'b0;
        tick(3);

        // Reset values
        check("rst calib_done", calib_done, 0);
        check("rst cmd_empty", cmd_empty, 1);
        check("rst wr_empty", wr_empty, 1);
        check("rst rd_empty", rd_empty, 1);
        check("rst rd_data", rd_data, 0);
        check("rst counts", {wr_count, rd_count}, 0);
        check("rst flags", {cmd_full, wr_full, rd_full, wr_underrun, wr_error, rd_overflow, rd_error}, 0);

        // Calibration: strobes are ignored until calib_done
        rst_i = 1'b0;
        cmd_en = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
        tick(1);
        cmd_en = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        tick(14);
        check("calib edge15", calib_done, 0);
        check("calib cmd ignored", cmd_empty, 1);
        check("calib wr ignored", wr_empty, 1);
        check("calib rd ignored", rd_error, 0);
        tick(1);
        check("calib edge16", calib_done, 1);

        // 8-word write then readback with latency checks
        for (int i = 0; i < 8; i++) push_wr(64'(17 * (i + 1)), 8'h00);
        check("wr_count 8", wr_count, 8);
        send_cmd(3'b000, 6'd7, 30'h40);
        tick(1);
        check("wr no pop at N+1", wr_count, 8);
        tick(1);
        check("wr first pop N+2", wr_count, 7);
        tick(10);
        check("wr drained", wr_empty, 1);
        send_cmd(3'b001, 6'd7, 30'h40);
        tick(2);
        check("rd empty at N+2", rd_empty, 1);
        tick(1);
        check("rd push at N+3", rd_count, 1);
        tick(8);
        check("rd_count 8", rd_count, 8);
        for (int i = 0; i < 8; i++) pop_check($sformatf("burst word %0d", i), 64'(17 * (i + 1)));
        check("rd drained", rd_empty, 1);

        // Byte mask
        push_wr(64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        do_write(6'd0, 30'h100);
        push_wr(64'h0, 8'h0F);
        do_write(6'd0, 30'h100);
        do_read(6'd0, 30'h100);
        pop_check("masked write", 64'h0000_0000_FFFF_FFFF);
        check("no underrun yet", wr_underrun, 0);

        // Underrun: 4-beat burst fed only 2 words
        for (int i = 0; i < 4; i++) push_wr(64'hAAAA_0000_0000_0000 + 64'(i), 8'h00);
        do_write(6'd3, 30'h200);
        push_wr(64'hBBBB_0000_0000_0000, 8'h00);
        push_wr(64'hBBBB_0000_0000_0001, 8'h00);
        do_write(6'd3, 30'h200);
        check("underrun set", wr_underrun, 1);
        do_read(6'd3, 30'h200);
        check("underrun rd_count", rd_count, 4);
        pop_check("underrun w0", 64'hBBBB_0000_0000_0000);
        pop_check("underrun w1", 64'hBBBB_0000_0000_0001);
        pop_check("underrun w2 old", 64'hAAAA_0000_0000_0002);
        pop_check("underrun w3 old", 64'hAAAA_0000_0000_0003);
        check("no overflow yet", rd_overflow, 0);

        // Overflow: two 64-word reads without popping
        send_cmd(3'b001, 6'd63, 30'h0);
        send_cmd(3'b001, 6'd63, 30'h0);
        tick(150);
        check("ovf rd_count", rd_count, 64);
        check("ovf rd_full", rd_full, 1);
        check("ovf flag", rd_overflow, 1);
        rd_en = 1'b1;
        tick(64);
        rd_en = 1'b0;
        check("ovf drained", rd_empty, 1);
        check("no rd_error yet", rd_error, 0);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("pop empty rd_error", rd_error, 1);

        // Address wrap: words at 1022, 1023, 0, 1
        for (int i = 0; i < 4; i++) push_wr(64'hCCCC_0000_0000_0000 + 64'(i), 8'h00);
        do_write(6'd3, 30'h1FF0);
        do_read(6'd1, 30'h0);
        pop_check("wrap idx0", 64'hCCCC_0000_0000_0002);
        pop_check("wrap idx1", 64'hCCCC_0000_0000_0003);

        // Reset mid-burst
        for (int i = 0; i < 8; i++) push_wr(64'h5555_5555_5555_5555, 8'h00);
        do_write(6'd7, 30'h400);
        for (int i = 0; i < 64; i++) push_wr(64'hE0E0_0000_0000_0000 + 64'(i), 8'h00);
        check("wr_full", wr_full, 1);
        check("no wr_error yet", wr_error, 0);
        push_wr(64'hDEAD_DEAD_DEAD_DEAD, 8'h00);
        check("push full wr_error", wr_error, 1);
        check("push full count", wr_count, 64);
        send_cmd(3'b000, 6'd63, 30'h400);
        tick(5);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        check("mid rst wr_empty", wr_empty, 1);
        check("mid rst rd_empty", rd_empty, 1);
        check("mid rst cmd_empty", cmd_empty, 1);
        check("mid rst flags", {wr_underrun, wr_error, rd_overflow, rd_error, calib_done}, 0);
        tick(16);
        check("recal done", calib_done, 1);
        do_read(6'd3, 30'h1FF0);
        for (int i = 0; i < 4; i++) pop_check($sformatf("kept wrap %0d", i), 64'hCCCC_0000_0000_0000 + 64'(i));
        do_read(6'd7, 30'h400);
        for (int i = 0; i < 4; i++) pop_check($sformatf("aborted new %0d", i), 64'hE0E0_0000_0000_0000 + 64'(i));
        for (int i = 4; i < 8; i++) pop_check($sformatf("aborted old %0d", i), 64'h5555_5555_5555_5555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
